nibble_serial_add_ctrl: RTL

- Sequencer that performs wide add/subtract by time-multiplexing one external 4-bit ripple adder (A, B, Cin -> Sum, Cout), one nibble per clock, LSB nibble first.
- Sits between a requester (start/done handshake, wide operands) and the shared 4-bit adder datapath.
- Latches the operands, drives the adder nibble by nibble, propagates the carry through a register, and assembles the wide result.

---
 rtl/nibble_serial_add_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Purpose:
//    Performs a wide add or subtract by time-multiplexing one external 4-bit
//    ripple adder. Each clock drives one nibble of the operands, least
//    significant nibble first. The carry between nibbles is held in a register.
//    The sum nibbles are collected into the wide result.
//
// Ports:
//    clk         in   system clock, rising edge
//    rst_n       in   asynchronous active-low reset
//    start       in   request, sampled only while idle
//    sub         in   0 = A+B, 1 = A-B (sampled with start)
//    op_a, op_b  in   4*NIBBLES-bit operands (sampled with start)
//    busy        out  high whenever the sequencer is not idle
//    done        out  one-cycle completion strobe
//    result      out  4*NIBBLES-bit sum/difference (modulo 2^(4*NIBBLES))
//    cout        out  final carry out (subtract: 1 = no borrow)
//    adder_a     out  nibble to external adder A
//    adder_b     out  nibble to external adder B (already inverted for subtract)
//    adder_cin   out  carry into external adder
//    adder_sum   in   external adder sum (combinational)
//    adder_cout  in   external adder carry out
//    ovf         out  signed overflow flag (only when SIGNED_OVF_EN is defined)
//
// Configuration:
//    Define SIGNED_OVF_EN to add the ovf output and its logic.
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   sub,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic [3:0]             adder_a,
   output logic [3:0]             adder_b,
   output logic                   adder_cin,
   input  logic [3:0]             adder_sum,
   input  logic                   adder_cout
`ifdef SIGNED_OVF_EN
   ,
   output logic                   ovf
`endif
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_next_s;
   logic [IW-1:0]   idx_r;
   logic [W-1:0]    a_sh_r;
   logic [W-1:0]    b_sh_r;
   logic [3:0]      adder_a_r;
   logic [3:0]      adder_b_r;
   logic            adder_cin_r;
   logic [W-1:0]    result_r;
   logic            cout_r;
   logic            busy_r;
   logic            done_r;
   logic            last_s;
`ifdef SIGNED_OVF_EN
   logic            ovf_r;
`endif

   // For subtract, B is inverted once here and the +1 enters as the first carry-in.
   function automatic logic [W-1:0] cond_invert(input logic [W-1:0] value, input logic inv);
      cond_invert = value ^ {W{inv}};
   endfunction

   assign last_s = (idx_r == IDX_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Status strobes are registered from the next state so that they line up with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_next_s != ST_IDLE);
         done_r <= (state_next_s == ST_DONE);
      end
   end

   // Operand latching, adder drive, carry chain and result assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r       <= {IW{1'b0}};
         a_sh_r      <= {W{1'b0}};
         b_sh_r      <= {W{1'b0}};
         adder_a_r   <= 4'd0;
         adder_b_r   <= 4'd0;
         adder_cin_r <= 1'b0;
         result_r    <= {W{1'b0}};
         cout_r      <= 1'b0;
`ifdef SIGNED_OVF_EN
         ovf_r       <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  // Nibble 0 is loaded straight into the drive registers.
                  // The shifters keep the remaining upper nibbles.
                  idx_r       <= {IW{1'b0}};
                  adder_a_r   <= op_a[3:0];
                  adder_b_r   <= op_b[3:0] ^ {4{sub}};
                  adder_cin_r <= sub;
                  a_sh_r      <= op_a >> 3'd4;
                  b_sh_r      <= cond_invert(op_b, sub) >> 3'd4;
               end else begin
                  idx_r       <= idx_r;
               end
            end
            ST_RUN: begin
               result_r[{idx_r, 2'b00} +: 4] <= adder_sum;
               idx_r <= idx_r + IDX_ONE;
               if (last_s) begin
                  cout_r      <= adder_cout;
`ifdef SIGNED_OVF_EN
                  ovf_r       <= (adder_a_r[3] == adder_b_r[3]) && (adder_sum[3] != adder_a_r[3]);
`endif
                  // Drive returns to zero once the operation leaves RUN.
                  adder_a_r   <= 4'd0;
                  adder_b_r   <= 4'd0;
                  adder_cin_r <= 1'b0;
               end else begin
                  adder_a_r   <= a_sh_r[3:0];
                  adder_b_r   <= b_sh_r[3:0];
                  adder_cin_r <= adder_cout;
                  a_sh_r      <= a_sh_r >> 3'd4;
                  b_sh_r      <= b_sh_r >> 3'd4;
               end
            end
            ST_DONE: begin
               idx_r <= idx_r;
            end
            default: begin
               idx_r <= {IW{1'b0}};
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign result    = result_r;
   assign cout      = cout_r;
   assign adder_a   = adder_a_r;
   assign adder_b   = adder_b_r;
   assign adder_cin = adder_cin_r;
`ifdef SIGNED_OVF_EN
   assign ovf       = ovf_r;
`endif

endmodule
